// File: rtl/note_game_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : note_game_pkg
//  Description : Shared types and song data for the note game blocks.
//  Revision    : 1.0 - initial release
// ============================================================================
package note_game_pkg;

    localparam int FREQ_W      = 16;
    localparam int c_max_songs = 2;
    localparam int c_max_notes = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        SERVE = 2'd2,
        DONE  = 2'd3
    } server_state_t;

    // Target note frequencies in Hz, one row per song.
    localparam logic [15:0] c_song_table [c_max_songs][c_max_notes] = '{
        '{16'd262, 16'd440, 16'd622, 16'd349, 16'd392, 16'd440, 16'd494, 16'd523,
          16'd587, 16'd659, 16'd698, 16'd784, 16'd698, 16'd659, 16'd587, 16'd523,
          16'd494, 16'd440, 16'd392, 16'd349, 16'd330, 16'd294, 16'd262, 16'd294,
          16'd330, 16'd349, 16'd392, 16'd440, 16'd494, 16'd523, 16'd587, 16'd523},
        '{16'd330, 16'd392, 16'd440, 16'd494, 16'd523, 16'd494, 16'd440, 16'd392,
          16'd349, 16'd392, 16'd440, 16'd349, 16'd330, 16'd294, 16'd262, 16'd294,
          16'd330, 16'd330, 16'd392, 16'd392, 16'd440, 16'd440, 16'd392, 16'd349,
          16'd349, 16'd330, 16'd330, 16'd294, 16'd294, 16'd262, 16'd262, 16'd262}
    };

    // Table lookup; anything outside the stored songs reads as a rest.
    function automatic logic [FREQ_W-1:0] song_freq(input int song, input int idx);
        if (song >= 0 && song < c_max_songs && idx >= 0 && idx < c_max_notes) begin
            return c_song_table[song][idx];
        end
        return '0;
    endfunction

endpackage
`default_nettype wire

// File: rtl/song_rom.sv
`default_nettype none
// ============================================================================
//  Module      : song_rom
//  Description : Song frequency ROM with a registered, 1-cycle read.
//  Revision    : 1.0 - initial release
// ============================================================================
module song_rom
    import note_game_pkg::*;
#(
    parameter int SONG_LEN  = 32,
    parameter int NUM_SONGS = 2,
    parameter int FREQ_W    = note_game_pkg::FREQ_W
) (
    input  logic                         pixel_clk_in,
    input  logic                         rst_in,
    input  logic [$clog2(NUM_SONGS)-1:0] song,
    input  logic [$clog2(SONG_LEN)-1:0]  idx,
    output logic [FREQ_W-1:0]            freq
);

    // Read every cycle; the caller decides which words it keeps.
    always_ff @(posedge pixel_clk_in or negedge rst_in) begin
        if (!rst_in) begin
            freq <= '0;
        end else begin
            freq <= FREQ_W'(song_freq(int'(song), int'(idx)));
        end
    end

endmodule
`default_nettype wire

// File: rtl/song_note_server.sv
`default_nettype none
// ============================================================================
//  Module      : song_note_server
//  Description : Answers note_req from the game with the next song note,
//                prefetching from song_rom into a small FIFO.
//  Revision    : 1.0 - initial release
// ============================================================================
module song_note_server
    import note_game_pkg::*;
#(
    parameter int SONG_LEN   = 32,
    parameter int NUM_SONGS  = 2,
    parameter int FIFO_DEPTH = 4,
    parameter int FREQ_W     = note_game_pkg::FREQ_W
) (
    input  logic                         pixel_clk_in,
    input  logic                         rst_in,
    input  logic                         start_in,
    input  logic [$clog2(NUM_SONGS)-1:0] song_sel_in,
    input  logic                         note_req_in,
    output logic [FREQ_W-1:0]            note_freq_out,
    output logic                         note_valid_out,
    output logic [$clog2(SONG_LEN)-1:0]  note_idx_out,
    output logic                         final_note_out,
    output logic                         busy_out,
    output logic                         underflow_out
);

    localparam int IDX_W   = $clog2(SONG_LEN);
    localparam int FETCH_W = IDX_W + 1;
    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int CNT_W   = PTR_W + 1;
    localparam int SONG_W  = $clog2(NUM_SONGS);

    localparam logic [FETCH_W-1:0] c_song_len = FETCH_W'(SONG_LEN);
    localparam logic [IDX_W-1:0]   c_last_idx = IDX_W'(SONG_LEN - 1);
    localparam logic [CNT_W-1:0]   c_depth    = CNT_W'(FIFO_DEPTH);

    server_state_t        r_state;
    server_state_t        w_state_next;
    logic                 r_req_d;
    logic                 r_pending;
    logic [SONG_W-1:0]    r_song_sel;
    logic [FETCH_W-1:0]   r_fetch_idx;
    logic                 r_in_flight;
    logic [IDX_W-1:0]     r_flight_idx;
    logic [CNT_W-1:0]     r_count;
    logic [PTR_W-1:0]     r_rd_ptr;
    logic [PTR_W-1:0]     r_wr_ptr;
    logic [FREQ_W-1:0]    r_fifo_freq [FIFO_DEPTH];
    logic [IDX_W-1:0]     r_fifo_idx  [FIFO_DEPTH];
    logic [FREQ_W-1:0]    r_note_freq;
    logic                 r_note_valid;
    logic [IDX_W-1:0]     r_note_idx;
    logic                 r_final;
    logic                 r_underflow;

    logic [FREQ_W-1:0]    w_rom_freq;
    logic                 w_req_pulse;
    logic                 w_active;
    logic                 w_empty;
    logic                 w_want;
    logic                 w_pop;
    logic                 w_push;
    logic                 w_issue;
    logic [CNT_W-1:0]     w_count_next;
    logic [FREQ_W-1:0]    w_head_freq;
    logic [IDX_W-1:0]     w_head_idx;
    logic                 w_last_pop;

    song_rom #(
        .SONG_LEN  (SONG_LEN),
        .NUM_SONGS (NUM_SONGS),
        .FREQ_W    (FREQ_W)
    ) u_song_rom (
        .pixel_clk_in (pixel_clk_in),
        .rst_in       (rst_in),
        .song         (r_song_sel),
        .idx          (r_fetch_idx[IDX_W-1:0]),
        .freq         (w_rom_freq)
    );

    // A held request level counts once; a pending request is retried each cycle.
    assign w_req_pulse  = note_req_in & ~r_req_d;
    assign w_active     = (r_state == FILL) || (r_state == SERVE);
    assign w_empty      = (r_count == '0);
    assign w_want       = w_req_pulse | r_pending;
    assign w_pop        = w_active & w_want & ~w_empty & ~start_in;
    // start_in flushes, so the word landing on a start cycle is dropped.
    assign w_push       = r_in_flight & ~start_in;
    // Reserve FIFO space at issue time so the returning word always fits.
    assign w_issue      = w_active & ~start_in
                        & ((r_count + CNT_W'(r_in_flight)) < c_depth)
                        & (r_fetch_idx < c_song_len);
    assign w_count_next = r_count + CNT_W'(w_push) - CNT_W'(w_pop);
    assign w_head_freq  = r_fifo_freq[r_rd_ptr];
    assign w_head_idx   = r_fifo_idx[r_rd_ptr];
    assign w_last_pop   = w_pop & (w_head_idx == c_last_idx);

    // Next-state selection; start_in overrides every state.
    always_comb begin
        w_state_next = r_state;
        if (start_in) begin
            w_state_next = FILL;
        end else begin
            case (r_state)
                IDLE:    w_state_next = IDLE;
                FILL: begin
                    if (w_last_pop) begin
                        w_state_next = DONE;
                    end else if ((w_count_next == c_depth) || (r_fetch_idx == c_song_len)) begin
                        w_state_next = SERVE;
                    end
                end
                SERVE:   if (w_last_pop) w_state_next = DONE;
                DONE:    w_state_next = DONE;
                default: w_state_next = IDLE;
            endcase
        end
    end

    // State, fetch/FIFO bookkeeping and registered outputs.
    always_ff @(posedge pixel_clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_state      <= IDLE;
            r_req_d      <= 1'b0;
            r_pending    <= 1'b0;
            r_song_sel   <= '0;
            r_fetch_idx  <= '0;
            r_in_flight  <= 1'b0;
            r_flight_idx <= '0;
            r_count      <= '0;
            r_rd_ptr     <= '0;
            r_wr_ptr     <= '0;
            r_note_freq  <= '0;
            r_note_valid <= 1'b0;
            r_note_idx   <= '0;
            r_final      <= 1'b0;
            r_underflow  <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_req_d      <= note_req_in;
            r_note_valid <= 1'b0;
            if (start_in) begin
                r_song_sel  <= song_sel_in;
                r_fetch_idx <= '0;
                r_in_flight <= 1'b0;
                r_count     <= '0;
                r_rd_ptr    <= '0;
                r_wr_ptr    <= '0;
                r_pending   <= 1'b0;
                r_final     <= 1'b0;
                r_underflow <= 1'b0;
            end else begin
                r_in_flight <= w_issue;
                if (w_issue) begin
                    r_fetch_idx  <= r_fetch_idx + FETCH_W'(1);
                    r_flight_idx <= r_fetch_idx[IDX_W-1:0];
                end
                if (w_push) begin
                    r_wr_ptr <= r_wr_ptr + PTR_W'(1);
                end
                if (w_pop) begin
                    r_rd_ptr     <= r_rd_ptr + PTR_W'(1);
                    r_note_valid <= 1'b1;
                    r_note_freq  <= w_head_freq;
                    r_note_idx   <= w_head_idx;
                    if (w_head_idx == c_last_idx) begin
                        r_final <= 1'b1;
                    end
                end else if ((r_state == DONE) && w_req_pulse) begin
                    r_note_valid <= 1'b1;
                    r_note_freq  <= '0;
                    r_note_idx   <= c_last_idx;
                end
                r_count   <= w_count_next;
                r_pending <= w_active & w_want & w_empty;
                if ((r_state == SERVE) && w_req_pulse && w_empty) begin
                    r_underflow <= 1'b1;
                end
            end
        end
    end

    // FIFO storage; needs no reset since count gates every read.
    always_ff @(posedge pixel_clk_in) begin
        if (w_push) begin
            r_fifo_freq[r_wr_ptr] <= w_rom_freq;
            r_fifo_idx[r_wr_ptr]  <= r_flight_idx;
        end
    end

    // A push can only land where space was reserved at issue time.
    always_ff @(posedge pixel_clk_in) begin
        if (rst_in) begin
            assert (!(w_push && (r_count == c_depth)));
        end
    end

    assign note_freq_out  = r_note_freq;
    assign note_valid_out = r_note_valid;
    assign note_idx_out   = r_note_idx;
    assign final_note_out = r_final;
    assign busy_out       = (r_state == FILL);
    assign underflow_out  = r_underflow;

endmodule
`default_nettype wire

// File: tb/tb_song_note_server.sv
`default_nettype none
// ============================================================================
//  Module      : tb_song_note_server
//  Description : Self-checking bench for song_note_server (8-note songs).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_song_note_server;

    localparam int SONG_LEN   = 8;
    localparam int NUM_SONGS  = 2;
    localparam int FIFO_DEPTH = 4;
    localparam int FREQ_W     = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [0:0]  sel;
    logic        req;
    logic [15:0] freq;
    logic        valid;
    logic [2:0]  idx;
    logic        fin;
    logic        busy;
    logic        uf;

    int n_cmp = 0;
    int n_bad = 0;

    // Expected opening notes of each song, in Hz.
    int song_tab [2][8] = '{'{262, 440, 622, 349, 392, 440, 494, 523},
                            '{330, 392, 440, 494, 523, 494, 440, 392}};

    typedef struct {
        int hold;
        int exp_freq;
        int exp_idx;
        int exp_fin;
    } vec_t;
    vec_t vecs [10];

    song_note_server #(
        .SONG_LEN   (SONG_LEN),
        .NUM_SONGS  (NUM_SONGS),
        .FIFO_DEPTH (FIFO_DEPTH),
        .FREQ_W     (FREQ_W)
    ) dut (
        .pixel_clk_in   (clk),
        .rst_in         (rst_n),
        .start_in       (start),
        .song_sel_in    (sel),
        .note_req_in    (req),
        .note_freq_out  (freq),
        .note_valid_out (valid),
        .note_idx_out   (idx),
        .final_note_out (fin),
        .busy_out       (busy),
        .underflow_out  (uf)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_song(input int s);
        start = 1'b1;
        sel   = 1'(s);
        tick();
        start = 1'b0;
    endtask

    task automatic wait_ready(input string name);
        int n = 0;
        while (busy && n < FIFO_DEPTH + 2) begin
            tick();
            n++;
        end
        check(name, 32'(busy), 0);
    endtask

    // Raise the request, expect one strobe right after, then silence.
    task automatic serve(input string name, input int hold, input int ef, input int ei, input int efin);
        req = 1'b1;
        tick();
        check({name, " valid"}, 32'(valid), 1);
        check({name, " freq"}, 32'(freq), 32'(ef));
        check({name, " idx"}, 32'(idx), 32'(ei));
        check({name, " final"}, 32'(fin), 32'(efin));
        for (int h = 1; h < hold; h++) begin
            tick();
            check({name, " held no strobe"}, 32'(valid), 0);
        end
        req = 1'b0;
        tick();
        check({name, " release no strobe"}, 32'(valid), 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got still running, want finished");
        $fatal(1);
    end

    initial begin
        int nv;
        int n;
        int s;
        int k;
        int nreq;
        int ef;
        int ei;

        // Song 0 walk: first note under a long hold, then one request every 2 cycles.
        vecs[0] = '{100, 262, 0, 0};
        vecs[1] = '{1, 440, 1, 0};
        vecs[2] = '{1, 622, 2, 0};
        vecs[3] = '{1, 349, 3, 0};
        vecs[4] = '{1, 392, 4, 0};
        vecs[5] = '{1, 440, 5, 0};
        vecs[6] = '{1, 494, 6, 0};
        vecs[7] = '{1, 523, 7, 1};
        vecs[8] = '{1, 0, 7, 1};
        vecs[9] = '{3, 0, 7, 1};

        rst_n = 1'b0;
        start = 1'b0;
        sel   = 1'b0;
        req   = 1'b0;
        repeat (3) tick();
        check("reset valid", 32'(valid), 0);
        check("reset freq", 32'(freq), 0);
        check("reset idx", 32'(idx), 0);
        check("reset final", 32'(fin), 0);
        check("reset busy", 32'(busy), 0);
        check("reset underflow", 32'(uf), 0);
        rst_n = 1'b1;
        tick();

        // Fill phase: busy while prefetching, no strobes without requests.
        start_song(0);
        check("fill busy", 32'(busy), 1);
        n  = 0;
        nv = 0;
        while (busy && n < FIFO_DEPTH + 2) begin
            tick();
            n++;
            if (valid) nv++;
        end
        check("fill busy drop", 32'(busy), 0);
        check("fill no early strobe", 32'(nv), 0);

        for (int i = 0; i < 10; i++) begin
            serve($sformatf("walk%0d", i), vecs[i].hold, vecs[i].exp_freq, vecs[i].exp_idx, vecs[i].exp_fin);
        end
        check("walk underflow", 32'(uf), 0);

        // Restart from DONE, with a request landing during FILL.
        start_song(0);
        check("restart final clear", 32'(fin), 0);
        req = 1'b1;
        tick();
        req = 1'b0;
        n = 0;
        while (!valid && n < 8) begin
            tick();
            n++;
        end
        check("fill req valid", 32'(valid), 1);
        check("fill req freq", 32'(freq), 262);
        check("fill req idx", 32'(idx), 0);
        check("fill req underflow", 32'(uf), 0);
        nv = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (valid) nv++;
        end
        check("fill req single strobe", 32'(nv), 0);
        wait_ready("fill req ready");
        serve("mid1", 1, 440, 1, 0);
        serve("mid2", 1, 622, 2, 0);
        serve("mid3", 1, 349, 3, 0);

        // Mid-song restart: nothing stale may be served.
        start_song(0);
        check("mid restart final", 32'(fin), 0);
        wait_ready("mid restart ready");
        serve("restart0", 1, 262, 0, 0);
        serve("restart1", 1, 440, 1, 0);

        // Asynchronous reset during FILL.
        start_song(0);
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("async valid", 32'(valid), 0);
        check("async freq", 32'(freq), 0);
        check("async idx", 32'(idx), 0);
        check("async final", 32'(fin), 0);
        check("async busy", 32'(busy), 0);
        check("async underflow", 32'(uf), 0);
        rst_n = 1'b1;
        tick();
        req = 1'b1;
        tick();
        check("idle ignores req", 32'(valid), 0);
        check("idle not busy", 32'(busy), 0);
        req = 1'b0;
        tick();
        start_song(1);
        wait_ready("song1 ready");
        serve("song1 n0", 1, 330, 0, 0);
        serve("song1 n1", 2, 392, 1, 0);

        // Randomized requests against a note-order model.
        for (int run = 0; run < 8; run++) begin
            s = int'($urandom_range(0, 1));
            start_song(s);
            k = 0;
            check("rnd start final", 32'(fin), 0);
            wait_ready("rnd ready");
            nreq = int'($urandom_range(4, 12));
            for (int j = 0; j < nreq; j++) begin
                if (j == 3 && $urandom_range(0, 2) == 0) begin
                    s = int'($urandom_range(0, 1));
                    start_song(s);
                    k = 0;
                    wait_ready("rnd restart ready");
                end
                for (int g = int'($urandom_range(0, 2)); g > 0; g--) begin
                    tick();
                    check("rnd gap no strobe", 32'(valid), 0);
                end
                ef = (k < SONG_LEN) ? song_tab[s][k] : 0;
                ei = (k < SONG_LEN) ? k : SONG_LEN - 1;
                if (k < SONG_LEN) k++;
                serve($sformatf("rnd%0d.%0d", run, j), int'($urandom_range(1, 3)), ef, ei,
                      (k >= SONG_LEN) ? 1 : 0);
            end
            check("rnd underflow", 32'(uf), 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/song_note_server.md
Name: song_note_server

Overview:
- Responder for the game's `note_req` handshake. It supplies the sequence of target note frequencies that the wall sprites display.
- Song table lives in a ROM sub-module. The block prefetches upcoming notes into a small FIFO so each request is answered in one cycle.
- Reports end-of-song (`final_note_out`), which drives the game FSM's PLAY->GAME_OVER transition.
- Sits between the song ROM and the note game, clocked on the pixel clock.

Parameters:
- SONG_LEN, 32, notes per song (index 0..SONG_LEN-1).
- NUM_SONGS, 2, songs in ROM.
- FIFO_DEPTH, 4, prefetch entries (power of 2, >=2).
- FREQ_W, 16, frequency width in Hz.

Ports:
- pixel_clk_in  in  1  single clock for the block.
- rst_in  in  1  asynchronous reset, active-low.
- start_in  in  1  one-cycle pulse; (re)starts the selected song from note 0.
- song_sel_in  in  $clog2(NUM_SONGS)  song select, sampled on start_in.
- note_req_in  in  1  request level from the game; may be held high for many cycles.
- note_freq_out  out  FREQ_W  frequency of the most recently served note.
- note_valid_out  out  1  one-cycle strobe; note_freq_out/note_idx_out updated this cycle.
- note_idx_out  out  $clog2(SONG_LEN)  index of the served note.
- final_note_out  out  1  high once note SONG_LEN-1 has been served; held until start_in.
- busy_out  out  1  high while in FILL.
- underflow_out  out  1  sticky; a request arrived with the FIFO empty. Cleared by start_in.

Behaviour:
- Reset (rst_in=0, async):
  - state=IDLE; all outputs 0.
  - FIFO count, read pointer, write pointer and rom fetch index = 0.
  - req_d=0; pending=0.
- Request detect: req_pulse = note_req_in & ~req_d, with req_d registered every cycle. A held level produces exactly one request.
- States:
  - IDLE: ignore requests. start_in -> FILL.
  - FILL: fetch from ROM. Go to SERVE when count==FIFO_DEPTH or all SONG_LEN notes have been fetched.
  - SERVE: pop on request; keep refilling.
  - DONE: entered on the cycle the note at index SONG_LEN-1 is served.
- start_in in any state:
  - Flush the FIFO; clear fetch index, pending, final_note_out and underflow_out.
  - Latch song_sel_in; go to FILL.
  - Any ROM data returning the following cycle is discarded.
- Fetch rules:
  - Issue a ROM read when count + in_flight < FIFO_DEPTH and fetch index < SONG_LEN.
  - ROM read latency is exactly 1 cycle; returned data is pushed on arrival.
  - Fetch index increments per issue.
- Serve rules:
  - On req_pulse (or pending) with FIFO non-empty: pop.
  - On the next cycle: note_valid_out=1, note_freq_out=entry freq, note_idx_out=entry idx.
  - Latency is 1 cycle from req_pulse.
- Empty on request (FILL, or SERVE starved):
  - Set pending=1 and underflow_out=1 (underflow_out only if state is SERVE).
  - Serve 1 cycle after the FIFO becomes non-empty.
- Requests in FILL are held as pending, not dropped. Only one pending request is held; further pulses while pending are dropped.
- Simultaneous push and pop: count unchanged, both occur. Push into a full FIFO cannot occur by construction; assert it never happens.
- DONE:
  - Each req_pulse yields note_valid_out=1 next cycle with note_freq_out=0 (rest), note_idx_out=SONG_LEN-1.
  - final_note_out stays 1.
- Width rules: fetch index is $clog2(SONG_LEN)+1 bits; count is $clog2(FIFO_DEPTH)+1 bits; no wrap of the fetch index.

Decomposition:
- Package note_game_pkg:
  - server_state_t enum {IDLE, FILL, SERVE, DONE}.
  - FREQ_W.
  - Song frequency constant arrays, e.g. song 0 begins 262,440,622,349,392,440,494,523.
- Sub-module song_rom:
  - Inputs: song, idx.
  - Output: registered freq, 1-cycle latency.
  - Shared with any future song preview block.

Test Plan:
1. Reset, then start_in with song_sel_in=0, SONG_LEN=8 -> busy_out high, then low within FIFO_DEPTH+2 cycles. No note_valid_out before any request.
2. note_req_in held high for 100 cycles -> exactly one note_valid_out, one cycle after the rise, with freq=262 and idx=0. Release and re-raise twice -> 440 (idx 1), then 622 (idx 2).
3. Request pulse on the same cycle as start_in+1 (during FILL) -> no drop. Served as 262 once the first ROM word lands; underflow_out stays 0.
4. Request every 2 cycles for the whole 8-note song -> all 8 freqs in order. After idx 7, final_note_out=1. Next request returns freq=0 with idx=7.
5. start_in mid-song (after idx 3 is served) -> FIFO flushed, final_note_out=0. Next request returns 262, idx 0, with no stale 392.
6. Assert rst_in low mid-FILL, asynchronously -> all outputs 0 immediately. A later start_in with song_sel_in=1 serves song 1's note 0.
